// File: rtl/img_pkg.sv
// Shared types, widths and helpers for the image-difference statistics path.
package img_pkg;

    localparam int PIX_W     = 4;
    localparam int FRAME_PIX = 9;
    localparam int SUM_W     = $clog2(FRAME_PIX * 15 + 1);

    typedef enum logic [0:0] {
        IDLE,
        ACCUM
    } stat_state_t;

    function automatic logic [PIX_W-1:0] abs_diff(
        input logic [PIX_W-1:0] d,
        input logic             signed_mode
    );
        logic [PIX_W-1:0] r;
        r = d;
        if (signed_mode && d[PIX_W-1]) begin
            r = ~d + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/img_abs4.sv
// Combinational magnitude of one 4-bit difference sample.
module img_abs4
    import img_pkg::*;
#(
    parameter bit SIGNED_MODE = 1'b1
) (
    input  logic [PIX_W-1:0] d,
    output logic [PIX_W-1:0] mag
);

    assign mag = abs_diff(d, SIGNED_MODE);

endmodule

// File: rtl/img_diff_stat.sv
// Reduces each 9-pixel difference frame to sum / max / argmax / changed-count.
module img_diff_stat
    import img_pkg::PIX_W;
    import img_pkg::stat_state_t;
    import img_pkg::IDLE;
    import img_pkg::ACCUM;
#(
    parameter int FRAME_PIX   = 9,
    parameter int THRESH      = 4,
    parameter bit SIGNED_MODE = 1'b1,
    localparam int IDX_W      = $clog2(FRAME_PIX),
    localparam int SUM_W      = $clog2(FRAME_PIX * 15 + 1),
    localparam int CNT_W      = $clog2(FRAME_PIX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_diff,
    output logic             out_valid,
    output logic [SUM_W-1:0] out_sum,
    output logic [PIX_W-1:0] out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_err
);

    stat_state_t state, state_nxt;

    logic [IDX_W-1:0] pix_cnt;
    logic [SUM_W-1:0] acc_sum;
    logic [PIX_W-1:0] acc_max;
    logic [IDX_W-1:0] acc_idx;
    logic [CNT_W-1:0] acc_cnt;

    logic [PIX_W-1:0] mag;
    logic             first;
    logic             last;
    logic             abort;
    logic             upd;
    logic [IDX_W-1:0] pix_idx;
    logic [SUM_W-1:0] m_sum;
    logic [PIX_W-1:0] m_max;
    logic [IDX_W-1:0] m_idx;
    logic [CNT_W-1:0] m_cnt;

    img_abs4 #(
        .SIGNED_MODE(SIGNED_MODE)
    ) u_abs (
        .d  (in_diff),
        .mag(mag)
    );

    // In IDLE the incoming pixel is index 0 and stale accumulators are ignored,
    // which gives back-to-back frames with no bubble.
    always_comb begin
        first   = (state == IDLE);
        pix_idx = first ? '0 : pix_cnt;
        upd     = first || (mag > acc_max);
        m_sum   = (first ? '0 : acc_sum) + SUM_W'(mag);
        m_max   = upd ? mag : acc_max;
        m_idx   = upd ? pix_idx : acc_idx;
        m_cnt   = (first ? '0 : acc_cnt) + CNT_W'(mag >= PIX_W'(THRESH));
        last    = in_valid && (pix_idx == IDX_W'(FRAME_PIX - 1));
        abort   = !first && !in_valid;

        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid && !last) state_nxt = ACCUM;
            ACCUM:   if (!in_valid || last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt   <= '0;
            acc_sum   <= '0;
            acc_max   <= '0;
            acc_idx   <= '0;
            acc_cnt   <= '0;
            out_sum   <= '0;
            out_max   <= '0;
            out_idx   <= '0;
            out_cnt   <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            out_valid <= last;
            out_err   <= abort;
            if (in_valid) begin
                acc_sum <= m_sum;
                acc_max <= m_max;
                acc_idx <= m_idx;
                acc_cnt <= m_cnt;
                pix_cnt <= last ? '0 : pix_idx + 1'b1;
                if (last) begin
                    out_sum <= m_sum;
                    out_max <= m_max;
                    out_idx <= m_idx;
                    out_cnt <= m_cnt;
                end
            end else if (abort) begin
                pix_cnt <= '0;
                acc_sum <= '0;
                acc_max <= '0;
                acc_idx <= '0;
                acc_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_img_diff_stat.sv
// Directed scoreboard bench for img_diff_stat (signed DUT plus unsigned twin).
module tb_img_diff_stat;

    typedef struct {
        int sum;
        int max;
        int idx;
        int cnt;
    } exp_t;

    typedef logic [3:0] frame_t [9];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_diff = '0;

    logic       out_valid, out_err;
    logic [7:0] out_sum;
    logic [3:0] out_max, out_idx, out_cnt;

    logic       u_valid, u_err;
    logic [7:0] u_sum;
    logic [3:0] u_max, u_idx, u_cnt;

    int vec  = 0;
    int errs = 0;
    int cyc  = 0;
    int n_valid = 0;
    int n_err   = 0;
    exp_t q[$];
    int   vtimes[$];

    img_diff_stat #(.FRAME_PIX(9), .THRESH(4), .SIGNED_MODE(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_diff(in_diff),
        .out_valid(out_valid), .out_sum(out_sum), .out_max(out_max),
        .out_idx(out_idx), .out_cnt(out_cnt), .out_err(out_err)
    );

    img_diff_stat #(.FRAME_PIX(9), .THRESH(4), .SIGNED_MODE(1'b0)) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_diff(in_diff),
        .out_valid(u_valid), .out_sum(u_sum), .out_max(u_max),
        .out_idx(u_idx), .out_cnt(u_cnt), .out_err(u_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input int obs, input int exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input frame_t f, input bit sm);
        exp_t e;
        int   a;
        e = '{0, -1, 0, 0};
        for (int i = 0; i < 9; i++) begin
            a = int'(f[i]);
            if (sm && a >= 8) a = 16 - a;
            e.sum += a;
            if (a > e.max) begin
                e.max = a;
                e.idx = i;
            end
            if (a >= 4) e.cnt++;
        end
        return e;
    endfunction

    task automatic send(input frame_t f, input int n, input bit keep);
        if (n == 9) q.push_back(model(f, 1'b1));
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_diff  = f[i];
        end
        if (!keep) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_diff  = '0;
        end
    endtask

    task automatic check_fields(input string tag, input exp_t e);
        chk({tag, "_sum"}, int'(out_sum), e.sum);
        chk({tag, "_max"}, int'(out_max), e.max);
        chk({tag, "_idx"}, int'(out_idx), e.idx);
        chk({tag, "_cnt"}, int'(out_cnt), e.cnt);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                n_valid++;
                vtimes.push_back(cyc);
                chk("err_with_valid", int'(out_err), 0);
                chk("sb_nonempty", int'(q.size() != 0), 1);
                if (q.size() != 0) check_fields("res", q.pop_front());
            end
            if (out_err) n_err++;
        end
    end

    initial begin
        frame_t f1, f2, f3, f6;
        exp_t   e, eu;
        int     nv, ne;

        f1 = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        f2 = '{default: 4'hF};
        f3 = '{4'h3, 4'h7, 4'h7, 4'h2, 4'h7, 4'h0, 4'h0, 4'h0, 4'h1};
        f6 = '{default: 4'h2};

        repeat (3) @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_err", int'(out_err), 0);
        check_fields("rst", '{0, 0, 0, 0});
        rst = 1'b0;

        // T1
        send(f1, 9, 1'b0);
        repeat (3) @(negedge clk);
        chk("t1_pulses", n_valid, 1);

        // T2 signed and unsigned views of the same stream
        send(f2, 9, 1'b0);
        repeat (3) @(negedge clk);
        eu = model(f2, 1'b0);
        chk("t2u_sum", int'(u_sum), eu.sum);
        chk("t2u_max", int'(u_max), eu.max);
        chk("t2u_idx", int'(u_idx), eu.idx);
        chk("t2u_cnt", int'(u_cnt), eu.cnt);

        // T3 ties keep the lowest index
        send(f3, 9, 1'b0);
        repeat (3) @(negedge clk);

        // T4 back-to-back frames
        nv = n_valid;
        ne = n_err;
        send(f1, 9, 1'b1);
        send(f1, 9, 1'b0);
        repeat (3) @(negedge clk);
        chk("t4_pulses", n_valid - nv, 2);
        chk("t4_spacing", vtimes[$] - vtimes[$-1], 9);
        chk("t4_no_err", n_err - ne, 0);

        // T5 abort mid-frame
        nv = n_valid;
        send(f1, 5, 1'b0);
        repeat (3) @(negedge clk);
        chk("t5_err", n_err - ne, 1);
        chk("t5_no_valid", n_valid - nv, 0);
        e = model(f1, 1'b1);
        check_fields("t5_held", e);
        send(f1, 9, 1'b0);
        repeat (3) @(negedge clk);
        chk("t5_after", n_valid - nv, 1);

        // T6 reset mid-frame
        send(f1, 4, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_valid", int'(out_valid), 0);
        chk("t6_err", int'(out_err), 0);
        check_fields("t6_rst", '{0, 0, 0, 0});
        @(negedge clk);
        rst = 1'b0;
        send(f6, 9, 1'b0);
        repeat (3) @(negedge clk);

        chk("sb_drained", q.size(), 0);
        chk("total_err", n_err, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
